cpu_bus_responder: RTL and testbench
====================================

Name: cpu_bus_responder

Overview:
- Responder for the NesCpu core's memory request interface. It answers every CPU access.
- Internal 2 KB work RAM is served directly, mirrored across $0000-$1FFF.
- Cartridge space ($4020-$FFFF) is reached by sequencing a full external cartridge-connector bus cycle: CPU_A, ROMSEL, M2, R/W and the data bus.
- $2000-$401F is answered as open bus. This block sits between NesCpu and the board pins, replacing the hard-wired data stub.

Parameters:
- SETUP_CYCLES, 2, clocks the address and R/W are driven with M2 low before the strobe (legal range ≥1).
- STROBE_CYCLES, 4, clocks M2 is high (and ROMSEL low for $8000-$FFFF); read data is sampled on the last one (legal range ≥1).

Ports:
- clock  in  1  system clock; everything updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_rw  in  1  1 = read, 0 = write (6502 sense).
- cpu_addr  in  16  access address.
- cpu_wdata  in  8  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data; valid while cpu_ack is high, held until the next ack.
- busy  out  1  high from the cycle after an accepted request until cpu_ack inclusive.
- cart_a  out  15  cartridge address pins, = addr[14:0].
- cart_romsel  out  1  active-low ROM select.
- cart_m2  out  1  cartridge phase-2 strobe.
- cart_rw  out  1  cartridge R/W.
- cart_d_out  out  8  cartridge data out.
- cart_d_oe  out  1  data-bus drive enable (tri-state is resolved at the top level).
- cart_d_in  in  8  cartridge data in.

Behaviour:
- Reset values: cpu_ack=0, cpu_rdata=0, busy=0, cart_a=0, cart_romsel=1, cart_m2=0, cart_rw=1, cart_d_out=0, cart_d_oe=0. The open-bus latch resets to 0 and the state machine to IDLE.
- RAM contents are not reset.
- Reset mid-transaction: the next cycle shows the reset values and no cpu_ack is issued for the aborted access.
- Address decode:
  - RAM: addr < $2000; RAM index = addr[10:0].
  - OPEN: $2000-$401F.
  - CART: ≥ $4020.
  - ROM: CART with addr[15] = 1.
- States: IDLE, RAM, OPEN, SETUP, STROBE, HOLD.
- IDLE with cpu_req=1 latches addr, rw and wdata, then moves to:
  - RAM for RAM addresses;
  - OPEN for OPEN addresses;
  - SETUP for CART addresses.
- cpu_req outside IDLE is ignored; the request is not queued.
- RAM state, one cycle:
  - write: stores wdata; cpu_rdata = wdata.
  - read: cpu_rdata = RAM[index].
  - cpu_ack = 1, then back to IDLE.
  - Latency: ack is visible 1 cycle after the request cycle.
- OPEN state, one cycle:
  - cpu_rdata = open-bus latch; writes are discarded.
  - cpu_ack = 1, then back to IDLE.
- SETUP, lasting SETUP_CYCLES cycles:
  - cart_a = addr[14:0]; cart_rw = rw; cart_m2 = 0; cart_romsel = 1.
  - On writes: cart_d_out = wdata and cart_d_oe = 1.
- STROBE, lasting STROBE_CYCLES cycles:
  - Same as SETUP, plus cart_m2 = 1.
  - cart_romsel = 0 iff ROM.
  - On reads, cart_d_in is captured at the end of the last strobe cycle.
- HOLD, one cycle:
  - cart_m2 = 0; cart_romsel = 1; cart_d_oe = 0; cart_rw = 1; cart_a is held.
  - cpu_ack = 1; cpu_rdata = captured data (read) or wdata (write).
  - Then IDLE.
- CART latency: ack is visible SETUP_CYCLES + STROBE_CYCLES + 1 cycles after the request cycle (7 with defaults).
- cart_a keeps its last value while IDLE; the other cart outputs return to their reset values.
- Open-bus latch: loaded with cpu_rdata on every completed RAM or CART access (reads and writes). OPEN accesses leave it unchanged.
- The phase counter is wide enough for max(SETUP_CYCLES, STROBE_CYCLES). It reloads on each phase entry and never wraps within a transaction.
- Back-to-back operation: a req in the cycle after ack (state IDLE) is accepted.

Decomposition:
- Shared package nes_bus_pkg holds:
  - typedef bus_state_t (the six states);
  - constants RAM_TOP=$1FFF, CART_BASE=$4020, RAM_AW=11.
- One sub-module, cpu_ram_2k: 2048x8 synchronous RAM with single-port write-first behaviour.

Test Plan:
1. Reset check: hold reset for 3 cycles and sample all outputs -> each output equals its reset value; cart_romsel=1; busy=0.
2. RAM mirror: write $0005=$A5 (ack +1), then read $0805 -> ack 1 cycle after the request; cpu_rdata=$A5; no cart pin activity.
3. ROM read: read $8000 with cart_d_in=$F0 during strobe ->
   - cart_a=$0000;
   - cart_m2 high and cart_romsel low for exactly 4 cycles, coincident;
   - cart_d_oe=0 throughout;
   - ack at +7 with cpu_rdata=$F0.
4. Cart write: write $6001=$3C ->
   - cart_romsel stays 1; cart_a=$6001;
   - cart_rw=0 and cart_d_oe=1 with cart_d_out=$3C for 6 cycles;
   - M2 high for the last 4 of those 6;
   - ack at +7.
5. Open bus and busy: immediately after test 4, read $2002 -> ack +1 with cpu_rdata=$3C. A cpu_req pulsed during a ROM read's busy window produces no extra ack.
6. Reset mid-transaction: assert reset in the second STROBE cycle -> the next cycle has cart_m2=0, cart_romsel=1, cart_d_oe=0 and no cpu_ack. A following ROM read completes normally at +7.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared types and address-map constants for the NesCpu bus responder.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAM,
    ST_OPEN,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } bus_state_t;

  localparam logic [15:0] RAM_TOP   = 16'h1FFF;
  localparam logic [15:0] CART_BASE = 16'h4020;
  localparam int unsigned RAM_AW    = 11;
  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

  // Work RAM and its mirrors occupy everything up to RAM_TOP.
  function automatic logic is_ram(input logic [15:0] addr);
    return addr <= RAM_TOP;
  endfunction

  // Cartridge connector space starts at CART_BASE.
  function automatic logic is_cart(input logic [15:0] addr);
    return addr >= CART_BASE;
  endfunction

endpackage

// File: rtl/cpu_ram_2k.sv
// 2048x8 single-port synchronous work RAM, write-first on the read port.
module cpu_ram_2k
  import nes_bus_pkg::*;
(
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [RAM_AW-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [RAM_DEPTH];
  logic [7:0] rdata_q;

  // Access port: a write also presents the written byte on the read data.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_q       <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_bus_responder.sv
// Answers NesCpu memory requests: work RAM, open bus, or a full cartridge bus cycle.
module cpu_bus_responder
  import nes_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        busy,
  output logic [14:0] cart_a,
  output logic        cart_romsel,
  output logic        cart_m2,
  output logic        cart_rw,
  output logic [7:0]  cart_d_out,
  output logic        cart_d_oe,
  input  logic [7:0]  cart_d_in
);

  localparam int unsigned CNT_MAX = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);

  bus_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic             rw_q, rw_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             ack_q, ack_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             busy_q, busy_d;
  logic [7:0]       open_q, open_d;
  logic [14:0]      cart_a_q, cart_a_d;
  logic             romsel_q, romsel_d;
  logic             m2_q, m2_d;
  logic             crw_q, crw_d;
  logic [7:0]       dout_q, dout_d;
  logic             oe_q, oe_d;
  logic             ram_en_c, ram_we_c;
  logic [7:0]       ram_rdata;

  cpu_ram_2k u_ram (
    .clk_i   (clock),
    .en_i    (ram_en_c),
    .we_i    (ram_we_c),
    .addr_i  (cpu_addr[RAM_AW-1:0]),
    .wdata_i (cpu_wdata),
    .rdata_o (ram_rdata)
  );

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b1;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      open_q   <= '0;
      cart_a_q <= '0;
      romsel_q <= 1'b1;
      m2_q     <= 1'b0;
      crw_q    <= 1'b1;
      dout_q   <= '0;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      open_q   <= open_d;
      cart_a_q <= cart_a_d;
      romsel_q <= romsel_d;
      m2_q     <= m2_d;
      crw_q    <= crw_d;
      dout_q   <= dout_d;
      oe_q     <= oe_d;
    end
  end

  // Next state, phase counting, and the pin values to present in the next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    ack_d    = 1'b0;
    rdata_d  = rdata_q;
    open_d   = open_q;
    cart_a_d = cart_a_q;
    romsel_d = 1'b1;
    m2_d     = 1'b0;
    crw_d    = 1'b1;
    dout_d   = '0;
    oe_d     = 1'b0;
    ram_en_c = 1'b0;
    ram_we_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          rw_d    = cpu_rw;
          wdata_d = cpu_wdata;
          if (is_ram(cpu_addr)) begin
            state_d  = ST_RAM;
            ack_d    = 1'b1;
            ram_en_c = !reset;
            ram_we_c = !reset && !cpu_rw;
          end else if (is_cart(cpu_addr)) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LOAD;
          end else begin
            state_d = ST_OPEN;
            ack_d   = 1'b1;
            rdata_d = open_q;
          end
        end
      end
      ST_RAM: begin
        state_d = ST_IDLE;
        rdata_d = ram_rdata;
        open_d  = ram_rdata;
      end
      ST_OPEN: begin
        state_d = ST_IDLE;
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          ack_d   = 1'b1;
          rdata_d = rw_q ? cart_d_in : wdata_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        open_d  = rdata_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_SETUP || state_d == ST_STROBE) begin
      cart_a_d = addr_d[14:0];
      crw_d    = rw_d;
      if (!rw_d) begin
        dout_d = wdata_d;
        oe_d   = 1'b1;
      end
      if (state_d == ST_STROBE) begin
        m2_d     = 1'b1;
        romsel_d = !addr_d[15];
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign cpu_ack     = ack_q;
  assign cpu_rdata   = (state_q == ST_RAM) ? ram_rdata : rdata_q;
  assign busy        = busy_q;
  assign cart_a      = cart_a_q;
  assign cart_romsel = romsel_q;
  assign cart_m2     = m2_q;
  assign cart_rw     = crw_q;
  assign cart_d_out  = dout_q;
  assign cart_d_oe   = oe_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed plus randomized checks of cpu_bus_responder against an address-map model.
module tb_cpu_bus_responder;

  localparam int S = 2;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        busy;
  logic [14:0] cart_a;
  logic        cart_romsel;
  logic        cart_m2;
  logic        cart_rw;
  logic [7:0]  cart_d_out;
  logic        cart_d_oe;
  logic [7:0]  cart_d_in;

  always #5 clk = ~clk;

  cpu_bus_responder #(.SETUP_CYCLES(S), .STROBE_CYCLES(T)) dut (
    .clock       (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_rw      (cpu_rw),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .busy        (busy),
    .cart_a      (cart_a),
    .cart_romsel (cart_romsel),
    .cart_m2     (cart_m2),
    .cart_rw     (cart_rw),
    .cart_d_out  (cart_d_out),
    .cart_d_oe   (cart_d_oe),
    .cart_d_in   (cart_d_in)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: work RAM image and the open-bus byte.
  logic [7:0] ref_ram [2048];
  logic [7:0] ref_ob;

  // Observations from the most recent access.
  int         lat;
  logic [7:0] rd;
  int         m2_cnt, rs_cnt, coinc_bad, oe_cnt, rwlo_cnt, dout_bad, a_bad, busy_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and watch the pins until ack (bounded); optionally pulse req mid-flight.
  task automatic access(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                        input logic [7:0] din, input int glitch);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = a; cpu_rw = rw; cpu_wdata = wd; cart_d_in = din;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom); cpu_rw = 1'($urandom);
    lat = 0; rd = '0;
    m2_cnt = 0; rs_cnt = 0; coinc_bad = 0; oe_cnt = 0; rwlo_cnt = 0;
    dout_bad = 0; a_bad = 0; busy_bad = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      cpu_req = (i == glitch);
      if (busy !== 1'b1) busy_bad++;
      if (cart_m2) m2_cnt++;
      if (!cart_romsel) rs_cnt++;
      if (cart_m2 !== !cart_romsel) coinc_bad++;
      if (cart_d_oe) begin
        oe_cnt++;
        if (cart_d_out !== wd) dout_bad++;
      end
      if (!cart_rw) rwlo_cnt++;
      if (cart_a !== a[14:0]) a_bad++;
      if (cpu_ack === 1'b1) begin
        lat = i;
        rd  = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  // Run an access and compare it with what the address map predicts.
  task automatic run(input string tag, input logic [15:0] a, input logic rw,
                     input logic [7:0] wd, input logic [7:0] din, input int glitch);
    logic       is_r, is_c, is_rom;
    logic [7:0] exp_rd;
    is_r   = (a < 16'h2000);
    is_c   = (a >= 16'h4020);
    is_rom = is_c && (a >= 16'h8000);
    if (is_r)      exp_rd = rw ? ref_ram[a[10:0]] : wd;
    else if (is_c) exp_rd = rw ? din : wd;
    else           exp_rd = ref_ob;
    access(a, rw, wd, din, glitch);
    chk({tag, "_latency"}, 32'(lat), 32'(is_c ? S + T + 1 : 1));
    chk({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
    chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
    chk({tag, "_m2_cycles"}, 32'(m2_cnt), 32'(is_c ? T : 0));
    chk({tag, "_romsel_cycles"}, 32'(rs_cnt), 32'(is_rom ? T : 0));
    chk({tag, "_oe_cycles"}, 32'(oe_cnt), 32'((is_c && !rw) ? S + T : 0));
    chk({tag, "_rw_low_cycles"}, 32'(rwlo_cnt), 32'((is_c && !rw) ? S + T : 0));
    chk({tag, "_dout"}, 32'(dout_bad), 32'd0);
    if (is_c)   chk({tag, "_cart_a"}, 32'(a_bad), 32'd0);
    if (is_rom) chk({tag, "_m2_romsel_coincident"}, 32'(coinc_bad), 32'd0);
    if (is_r && !rw) ref_ram[a[10:0]] = wd;
    if (is_r || is_c) ref_ob = exp_rd;
  endtask

  // Count acks over an idle stretch; none are expected.
  task automatic quiet(input string tag, input int n);
    int acks;
    acks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) acks++;
    end
    chk(tag, 32'(acks), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    int          region;

    reset = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b1; cpu_addr = '0; cpu_wdata = '0; cart_d_in = '0;
    ref_ob = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cart_a", 32'(cart_a), 32'd0);
    chk("rst_romsel", 32'(cart_romsel), 32'd1);
    chk("rst_m2", 32'(cart_m2), 32'd0);
    chk("rst_rw", 32'(cart_rw), 32'd1);
    chk("rst_dout", 32'(cart_d_out), 32'd0);
    chk("rst_oe", 32'(cart_d_oe), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // RAM write then mirrored read.
    run("ram_wr", 16'h0005, 1'b0, 8'hA5, 8'h00, 0);
    run("ram_mirror", 16'h0805, 1'b1, 8'h00, 8'h00, 0);
    chk("ram_mirror_value", 32'(rd), 32'hA5);

    // ROM read.
    run("rom_rd", 16'h8000, 1'b1, 8'h00, 8'hF0, 0);
    chk("rom_rd_value", 32'(rd), 32'hF0);

    // Cartridge write followed immediately by an open-bus read.
    run("cart_wr", 16'h6001, 1'b0, 8'h3C, 8'h00, 0);
    chk("cart_wr_a", 32'(cart_a), 32'h6001);
    run("open_rd", 16'h2002, 1'b1, 8'h00, 8'h00, 0);
    chk("open_value", 32'(rd), 32'h3C);

    // A req pulsed while busy must be dropped.
    run("rom_glitch", 16'h8123, 1'b1, 8'h00, 8'($urandom), 3);
    quiet("glitch_no_extra_ack", 10);

    // Reset in the second strobe cycle.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 16'h8000; cpu_rw = 1'b1; cart_d_in = 8'h55;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_m2", 32'(cart_m2), 32'd0);
    chk("abort_romsel", 32'(cart_romsel), 32'd1);
    chk("abort_oe", 32'(cart_d_oe), 32'd0);
    chk("abort_ack", 32'(cpu_ack), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    ref_ob = '0;
    quiet("abort_no_ack", 10);
    run("rom_after_abort", 16'h8000, 1'b1, 8'h00, 8'h99, 0);

    // Seed a small RAM pool so random reads have known contents.
    for (int i = 0; i < 16; i++) begin
      a = {3'b000, 2'($urandom), 7'd0, 4'(i)};
      run("ram_seed", a, 1'b0, 8'($urandom), 8'h00, 0);
    end

    // Randomized traffic across all regions.
    for (int n = 0; n < 60; n++) begin
      region = int'($urandom_range(0, 3));
      case (region)
        0:       a = {3'b000, 2'($urandom), 7'd0, 4'($urandom)};
        1:       a = 16'(16'h2000 + $urandom_range(0, 32'h201F));
        2:       a = 16'(16'h4020 + $urandom_range(0, 32'h3FDF));
        default: a = 16'(16'h8000 + $urandom_range(0, 32'h7FFF));
      endcase
      run("random", a, 1'($urandom), 8'($urandom), 8'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
